instr_cache: RTL and testbench
==============================

// Module: instr_cache
// PURPOSE
// Responder for the fetch stage's instruction request: takes the fetch PC, returns the
// instruction word, and raises stall on a miss. Direct-mapped, read-only; refills whole
// lines from backing memory over a request/grant + rvalid burst. stall feeds the fetch stall.
// PARAMETERS
// DATA_WIDTH      32   address/instruction/memory word width
// LINES           16   cache lines (power of 2, >=2)
// WORDS_PER_LINE  4    32-bit words per line (power of 2, >=2)
// PORTS
// clk         in   1           clock, all state on rising edge
// reset       in   1           asynchronous, active-low reset
// addr        in   DATA_WIDTH  fetch PC (byte address; addr[1:0] ignored)
// flush       in   1           invalidate all lines
// instr       out  DATA_WIDTH  instruction for addr; 0x00000013 (NOP) while stall=1
// stall       out  1           1 = instr not valid this cycle, fetch must hold
// mem_req     out  1           refill request, held until mem_gnt
// mem_addr    out  DATA_WIDTH  line-aligned refill address
// mem_gnt     in   1           memory accepted request (sampled while mem_req=1)
// mem_rvalid  in   1           one refill word on mem_rdata, in ascending word order
// mem_rdata   in   DATA_WIDTH  refill data
// BEHAVIOUR
// - Address split: word = addr[WO+1:2], WO=log2(WORDS_PER_LINE); index = next log2(LINES)
//   bits; tag = remaining upper bits. Storage: data array, tag array, valid bit per line.
// - Reset (reset=0): all valid=0, state IDLE, mem_req=0, mem_addr=0, beat=0, flush_pend=0;
//   stall=1, instr=NOP while reset is low. mem_req drops immediately (async), even mid-burst.
// - FSM IDLE -> REQ -> FILL -> IDLE.
// - IDLE: hit = valid[index] & tag match (combinational). Hit: stall=0, instr=data same cycle.
//   Miss: stall=1, latch line address (addr, offset bits zeroed), clear valid[index], -> REQ.
// - REQ: mem_req=1, mem_addr=latched line address, stable until mem_gnt=1; on gnt -> FILL,
//   beat=0, mem_req=0 next cycle.
// - FILL: each mem_rvalid writes mem_rdata to data[latched index][beat], beat++. On beat
//   WORDS_PER_LINE-1: write tag, set valid (unless flush_pend), -> IDLE.
// - stall=1 in every REQ/FILL cycle. Miss latency with addr held: detect cycle + grant wait
//   + WORDS_PER_LINE rvalid beats; hit on first IDLE cycle after last beat.
// - mem_rvalid outside FILL and mem_gnt outside REQ are ignored.
// - addr changing during REQ/FILL (fetch redirect): refill of latched line completes
//   regardless; new addr looked up on return to IDLE.
// - flush in IDLE: all valid cleared at next edge; stall=1 in the flush cycle.
//   flush in REQ/FILL: sets flush_pend; at refill completion all valid cleared (including
//   the line just filled), flush_pend=0.
// - Simultaneous flush and miss in IDLE: flush wins, no request issued that cycle.
// - No writes from fetch side; self-modifying code requires flush.
// TESTING (defaults: line = 16 B, index = addr[7:4], word = addr[3:2])
// 1 reset release, addr=0x0 -> stall=1, mem_req=1, mem_addr=0x0; gnt after 2 cycles,
//   beats 0x11,0x22,0x33,0x44 -> next cycle stall=0, instr=0x11; addr=0x8 -> instr=0x33,
//   stall=0, no mem_req.
// 2 conflict: line 0x0 resident, addr=0x100 -> miss, refill at mem_addr=0x100; then addr=0x0
//   -> miss again with mem_addr=0x0.
// 3 gnt delayed 5 cycles -> mem_req=1 and mem_addr constant all 5 cycles, stall=1 throughout;
//   stray mem_rvalid in IDLE/REQ leaves data unchanged.
// 4 flush pulse in IDLE with lines 0x0,0x10 valid -> addr=0x10 next cycle misses (mem_req=1).
//   flush during FILL beat 1 -> after last beat addr still misses, new request issued.
// 5 reset low after 2 FILL beats -> mem_req=0, stall=1 immediately; after release same addr
//   re-requests mem_addr=0x0 and needs all 4 beats before stall=0.
// 6 addr 0x20->0x40 mid-FILL (redirect) -> 0x20 line completes and valid; then 0x40 misses,
//   mem_addr=0x40; afterwards 0x24 hits.

Source files
------------

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache for the fetch stage.
// A miss refills one whole line from backing memory: a request/grant handshake, then an rvalid burst.
module instr_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  stall,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WO  = $clog2(WORDS_PER_LINE);
  localparam int IW  = $clog2(LINES);
  localparam int OFS = WO + 2;
  localparam int TW  = DATA_WIDTH - IW - OFS;
  localparam logic [DATA_WIDTH-1:0] NOP       = DATA_WIDTH'(32'h0000_0013);
  localparam logic [WO-1:0]         LAST_BEAT = WO'(WORDS_PER_LINE - 1);
  localparam logic [WO-1:0]         BEAT_ONE  = WO'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t                state_r;
  logic [LINES-1:0]      valid_r;
  logic [TW-1:0]         tag_r  [LINES];
  logic [DATA_WIDTH-1:0] data_r [LINES*WORDS_PER_LINE];
  logic [WO-1:0]         beat_r;
  logic                  flush_pend_r;
  logic                  mem_req_r;
  logic [DATA_WIDTH-1:0] mem_addr_r;

  logic [IW-1:0]         index_s;
  logic [WO-1:0]         word_s;
  logic [TW-1:0]         tag_s;
  logic [IW-1:0]         fill_index_s;
  logic [TW-1:0]         fill_tag_s;
  logic [DATA_WIDTH-1:0] line_base_s;
  logic                  hit_s;
  logic                  fill_we_s;
  logic                  fill_last_s;
  logic [1:0]            unused_addr_s;

  assign index_s       = addr[OFS +: IW];
  assign word_s        = addr[2 +: WO];
  assign tag_s         = addr[DATA_WIDTH-1 -: TW];
  assign line_base_s   = {addr[DATA_WIDTH-1:OFS], {OFS{1'b0}}};
  assign unused_addr_s = addr[1:0];

  // The latched refill address doubles as the fill target for index and tag.
  assign fill_index_s = mem_addr_r[OFS +: IW];
  assign fill_tag_s   = mem_addr_r[DATA_WIDTH-1 -: TW];
  assign fill_we_s    = (state_r == FILL) && mem_rvalid;
  assign fill_last_s  = fill_we_s && (beat_r == LAST_BEAT);

  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;

  // Hit lookup, only meaningful while idle.
  always_comb begin
    hit_s = 1'b0;
    if ((state_r == IDLE) && valid_r[index_s] && (tag_r[index_s] == tag_s)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Same-cycle hit response; a flush cycle stalls even on a hit since the line is going away.
  always_comb begin
    stall = 1'b1;
    instr = NOP;
    if (reset && hit_s && !flush) begin
      stall = 1'b0;
      instr = data_r[{index_s, word_s}];
    end else begin
      stall = 1'b1;
      instr = NOP;
    end
  end

  // Line storage; contents are qualified by valid_r so they need no reset.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      data_r[{fill_index_s, beat_r}] <= mem_rdata;
    end
    if (fill_last_s) begin
      tag_r[fill_index_s] <= fill_tag_s;
    end
  end

  // Refill controller: miss detection, memory handshake, beat counting and flush handling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      valid_r      <= '0;
      beat_r       <= '0;
      flush_pend_r <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (flush) begin
            valid_r <= '0;
          end else if (!hit_s) begin
            mem_addr_r       <= line_base_s;
            mem_req_r        <= 1'b1;
            valid_r[index_s] <= 1'b0;
            state_r          <= REQ;
          end
        end
        REQ: begin
          if (flush) begin
            flush_pend_r <= 1'b1;
          end
          if (mem_gnt) begin
            mem_req_r <= 1'b0;
            beat_r    <= '0;
            state_r   <= FILL;
          end
        end
        FILL: begin
          if (fill_last_s) begin
            // A flush seen at any point during the refill also drops the fresh line.
            if (flush_pend_r || flush) begin
              valid_r <= '0;
            end else begin
              valid_r[fill_index_s] <= 1'b1;
            end
            flush_pend_r <= 1'b0;
            beat_r       <= '0;
            state_r      <= IDLE;
          end else begin
            if (flush) begin
              flush_pend_r <= 1'b1;
            end
            if (fill_we_s) begin
              beat_r <= beat_r + BEAT_ONE;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: a backing-memory responder checks refill requests,
// the fetch side checks returned instructions and miss latency.
module tb_instr_cache;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] req_q[$];
  int   gnt_delay = 0;
  logic stray_en = 1'b0;
  int   beats_sent = 0;
  int   grants = 0;

  always #5 clk = ~clk;

  instr_cache dut (
    .clk(clk), .reset(reset), .addr(addr), .flush(flush),
    .instr(instr), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a < 32'h10) return 32'h11 * ({30'h0, a[3:2]} + 32'h1);
    else return 32'hC000_0000 | a;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic request_only(input logic [31:0] a);
    addr = a;
    req_q.push_back(a & 32'hFFFF_FFF0);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input bit miss);
    addr = a;
    exp_q.push_back(mem_val(a & 32'hFFFF_FFFC));
    if (miss) req_q.push_back(a & 32'hFFFF_FFF0);
    #1;
  endtask

  task automatic await_out(input string tag, input int exp_lat);
    int n = 0;
    logic [31:0] e;
    while (stall !== 1'b0 && n < 200) begin
      cyc();
      n++;
    end
    check_eq({tag, "_ready"}, {31'h0, stall}, 32'h0);
    check_eq({tag, "_qpend"}, {31'h0, exp_q.size() > 0}, 32'h1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    check_eq({tag, "_instr"}, instr, e);
    if (exp_lat >= 0) check_eq({tag, "_lat"}, n, exp_lat);
  endtask

  // Backing-memory model: grants after gnt_delay REQ cycles, then streams four beats.
  initial begin
    int   req_wait = 0;
    int   beat_idx = 0;
    logic in_fill = 1'b0;
    logic [31:0] fill_addr = 32'h0;
    logic [31:0] held_addr = 32'h0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = 32'h0;
      if (!reset) begin
        in_fill = 1'b0;
        req_wait = 0;
      end else if (in_fill) begin
        mem_rvalid = 1'b1;
        mem_rdata = mem_val(fill_addr + 32'(beat_idx * 4));
        beat_idx++;
        beats_sent++;
        if (beat_idx == 4) in_fill = 1'b0;
      end else if (mem_req) begin
        if (req_wait == 0) held_addr = mem_addr;
        else check_eq("req_hold", mem_addr, held_addr);
        check_eq("req_stall", {31'h0, stall}, 32'h1);
        if (stray_en) begin
          mem_rvalid = 1'b1;
          mem_rdata = 32'hDEAD_BEEF;
        end
        if (req_wait >= gnt_delay) begin
          mem_gnt = 1'b1;
          grants++;
          check_eq("req_pending", {31'h0, req_q.size() > 0}, 32'h1);
          if (req_q.size() > 0) check_eq("req_addr", mem_addr, req_q.pop_front());
          fill_addr = mem_addr;
          beat_idx = 0;
          in_fill = 1'b1;
          req_wait = 0;
        end else begin
          req_wait++;
        end
      end else if (stray_en) begin
        mem_gnt = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int g0;
    repeat (3) cyc();
    check_eq("rst_stall", {31'h0, stall}, 32'h1);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_maddr", mem_addr, 32'h0);

    // 1: first miss after reset, then hits in the same line
    gnt_delay = 2;
    reset = 1'b1;
    issue(32'h0, 1'b1);
    check_eq("t1_detect_req", {31'h0, mem_req}, 32'h0);
    check_eq("t1_detect_instr", instr, NOP);
    await_out("t1_fill", 8);
    issue(32'h8, 1'b0);
    check_eq("t1_hit_noreq", {31'h0, mem_req}, 32'h0);
    await_out("t1_hit", 0);
    issue(32'hA, 1'b0);
    await_out("t1_lowbits", 0);

    // 2: conflicting tags on the same index evict each other
    gnt_delay = 0;
    issue(32'h100, 1'b1);
    await_out("t2_conf", 6);
    issue(32'h0, 1'b1);
    await_out("t2_back", 6);

    // 3: slow grant with stray memory traffic outside the fill
    gnt_delay = 5;
    stray_en = 1'b1;
    issue(32'h60, 1'b1);
    await_out("t3_slow", 11);
    repeat (3) cyc();
    issue(32'h64, 1'b0);
    await_out("t3_hit64", 0);
    issue(32'h60, 1'b0);
    await_out("t3_hit60", 0);
    issue(32'h4, 1'b0);
    await_out("t3_old", 0);
    stray_en = 1'b0;
    gnt_delay = 0;

    // 4: flush in IDLE, flush racing a miss, flush during a fill
    issue(32'h10, 1'b1);
    await_out("t4_fill10", 6);
    issue(32'h0, 1'b0);
    await_out("t4_hit0", 0);
    issue(32'h10, 1'b0);
    await_out("t4_hit10", 0);
    flush = 1'b1;
    #1;
    check_eq("t4_flush_stall", {31'h0, stall}, 32'h1);
    cyc();
    flush = 1'b0;
    check_eq("t4_flush_noreq", {31'h0, mem_req}, 32'h0);
    issue(32'h10, 1'b1);
    await_out("t4_after_flush", 6);
    addr = 32'h30;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_eq("t4_flush_wins", {31'h0, mem_req}, 32'h0);
    issue(32'h30, 1'b1);
    await_out("t4_miss30", 6);
    issue(32'h10, 1'b1);
    await_out("t4_cleared10", 6);
    base = beats_sent;
    g0 = grants;
    request_only(32'h50);
    issue(32'h50, 1'b1);
    for (int i = 0; i < 100 && beats_sent < base + 1; i++) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    await_out("t4_flushfill", -1);
    check_eq("t4_regrant", grants - g0, 32'd2);
    issue(32'h30, 1'b1);
    await_out("t4_cleared30", 6);

    // 5: reset in the middle of a fill
    base = beats_sent;
    request_only(32'h70);
    for (int i = 0; i < 100 && beats_sent < base + 2; i++) cyc();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5_req", {31'h0, mem_req}, 32'h0);
    check_eq("t5_stall", {31'h0, stall}, 32'h1);
    check_eq("t5_instr", instr, NOP);
    check_eq("t5_maddr", mem_addr, 32'h0);
    cyc();
    cyc();
    reset = 1'b1;
    issue(32'h70, 1'b1);
    await_out("t5_rereq", 6);

    // 6: fetch redirect while a refill is in flight
    base = beats_sent;
    request_only(32'h20);
    for (int i = 0; i < 100 && beats_sent < base + 2; i++) cyc();
    issue(32'h40, 1'b1);
    await_out("t6_redir", -1);
    issue(32'h24, 1'b0);
    await_out("t6_hit24", 0);

    repeat (3) cyc();
    check_eq("req_q_empty", req_q.size(), 32'd0);
    check_eq("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
